// File: rtl/dmi_initiator.sv
// dmi_initiator: issues one DMI command at a time toward a debug module,
// re-issues on busy responses up to MaxRetries and returns a single result.
// Optional whole-command timeout is built when DMI_INITIATOR_TIMEOUT_EN is
// defined; without it the block waits indefinitely for the debug module.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting a command, draining stray DMI responses
// REQ    | offering the captured request to the debug module
// WAIT   | request accepted, waiting for the DMI response
// RSP    | presenting the result until rsp_ready_i
module dmi_initiator #(
   parameter int unsigned MaxRetries    = 4,
   parameter int unsigned TimeoutCycles = 1023
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [6:0]  cmd_addr_i,
   input  logic [1:0]  cmd_op_i,
   input  logic [31:0] cmd_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic [1:0]  rsp_status_o,
   output logic        dmi_req_valid_o,
   input  logic        dmi_req_ready_i,
   output logic [6:0]  dmi_req_addr_o,
   output logic [1:0]  dmi_req_op_o,
   output logic [31:0] dmi_req_data_o,
   input  logic        dmi_resp_valid_i,
   output logic        dmi_resp_ready_o,
   input  logic [1:0]  dmi_resp_resp_i,
   input  logic [31:0] dmi_resp_data_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   localparam logic [1:0] STAT_OK      = 2'd0;
   localparam logic [1:0] STAT_TIMEOUT = 2'd1;
   localparam logic [1:0] STAT_FAILED  = 2'd2;
   localparam logic [1:0] STAT_BUSY    = 2'd3;
   localparam logic [1:0] RESP_OK      = 2'd0;
   localparam logic [1:0] RESP_BUSY    = 2'd3;
   localparam logic [3:0] MAX_RETRY    = 4'(MaxRetries);

   state_t      state_q;
   state_t      state_d;
   logic [6:0]  addr_q;
   logic [1:0]  op_q;
   logic [31:0] data_q;
   logic [3:0]  retry_q;
   logic [31:0] rsp_data_q;
   logic [1:0]  rsp_status_q;
   logic        tmo_hit;
   logic        can_retry;
   logic        busy_resp;

   assign can_retry = (retry_q < MAX_RETRY);
   assign busy_resp = (dmi_resp_resp_i == RESP_BUSY);

`ifdef DMI_INITIATOR_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TimeoutCycles - 1);
   logic [15:0] tmo_q;

   // Whole-command cycle counter: cleared when a command is accepted, so busy
   // re-issues keep counting; saturates instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else if (state_q == ST_IDLE && cmd_valid_i) begin
         tmo_q <= '0;
      end else if ((state_q == ST_REQ || state_q == ST_WAIT) && tmo_q != 16'hFFFF) begin
         tmo_q <= tmo_q + 16'd1;
      end
   end

   // Fires in the cycle the counter reaches TimeoutCycles at the next edge.
   assign tmo_hit = (state_q == ST_REQ || state_q == ST_WAIT) && (tmo_q >= TMO_LAST);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^(16'(TimeoutCycles));
   assign tmo_hit        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a handshake in the same cycle as the timeout wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (dmi_req_ready_i)  state_d = ST_WAIT;
            else if (tmo_hit)     state_d = ST_RSP;
         end
         ST_WAIT: begin
            if (dmi_resp_valid_i) begin
               if (busy_resp && can_retry) state_d = ST_REQ;
               else                        state_d = ST_RSP;
            end else if (tmo_hit) begin
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command capture, retry count and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q       <= '0;
         op_q         <= '0;
         data_q       <= '0;
         retry_q      <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
      end else begin
         if (state_q == ST_IDLE && cmd_valid_i) begin
            addr_q <= cmd_addr_i;
            op_q   <= cmd_op_i;
            data_q <= cmd_data_i;
         end

         if (state_q == ST_RSP && rsp_ready_i) begin
            retry_q <= '0;
         end else if (state_q == ST_WAIT && dmi_resp_valid_i && busy_resp && can_retry) begin
            retry_q <= retry_q + 4'd1;
         end

         if (state_q == ST_REQ && !dmi_req_ready_i && tmo_hit) begin
            rsp_data_q   <= '0;
            rsp_status_q <= STAT_TIMEOUT;
         end else if (state_q == ST_WAIT && dmi_resp_valid_i) begin
            if (dmi_resp_resp_i == RESP_OK) begin
               rsp_data_q   <= dmi_resp_data_i;
               rsp_status_q <= STAT_OK;
            end else if (busy_resp) begin
               if (!can_retry) begin
                  rsp_data_q   <= '0;
                  rsp_status_q <= STAT_BUSY;
               end
            end else begin
               // Reserved code 1 is reported the same as a failure.
               rsp_data_q   <= dmi_resp_data_i;
               rsp_status_q <= STAT_FAILED;
            end
         end else if (state_q == ST_WAIT && tmo_hit) begin
            rsp_data_q   <= '0;
            rsp_status_q <= STAT_TIMEOUT;
         end
      end
   end

   // Output decode; everything is forced low while reset is held.
   always_comb begin
      cmd_ready_o      = 1'b0;
      busy_o           = 1'b0;
      dmi_req_valid_o  = 1'b0;
      dmi_req_addr_o   = '0;
      dmi_req_op_o     = '0;
      dmi_req_data_o   = '0;
      dmi_resp_ready_o = 1'b0;
      rsp_valid_o      = 1'b0;
      rsp_data_o       = '0;
      rsp_status_o     = '0;
      if (!rst_i) begin
         cmd_ready_o      = (state_q == ST_IDLE);
         busy_o           = (state_q != ST_IDLE);
         dmi_req_valid_o  = (state_q == ST_REQ);
         dmi_req_addr_o   = addr_q;
         dmi_req_op_o     = op_q;
         dmi_req_data_o   = data_q;
         dmi_resp_ready_o = (state_q == ST_IDLE) || (state_q == ST_WAIT);
         rsp_valid_o      = (state_q == ST_RSP);
         rsp_data_o       = rsp_data_q;
         rsp_status_o     = rsp_status_q;
      end
   end

endmodule

// File: doc/dmi_initiator.md
DMI_INITIATOR -- requirements
Module: dmi_initiator

Interface
REQ-001 Parameter MaxRetries, default 4: number of re-issues allowed after a DMI busy response (range 0..15).
REQ-002 Parameter TimeoutCycles, default 1023: maximum number of cycles to wait for a DMI handshake (range 1..65535).
REQ-003 clk_i  in  1  single clock; all logic is on the rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
REQ-006 cmd_addr_i  in  7  DMI register address.
REQ-007 cmd_op_i  in  2  DMI op: 0 nop, 1 read, 2 write.
REQ-008 cmd_data_i  in  32  write data.
REQ-009 rsp_valid_o / rsp_ready_i  out/in  1/1  result handshake.
REQ-010 rsp_data_o  out  32  read data.
REQ-011 rsp_status_o  out  2  result status: 0 ok, 1 timeout, 2 failed, 3 busy-exhausted.
REQ-012 dmi_req_valid_o / dmi_req_ready_i  out/in  1/1  DMI request handshake toward the debug module.
REQ-013 dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o  out  7, 2, 32  DMI request fields.
REQ-014 dmi_resp_valid_i / dmi_resp_ready_o  in/out  1/1  DMI response handshake.
REQ-015 dmi_resp_resp_i, dmi_resp_data_i  in  2, 32  DMI response code and data.
REQ-016 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT and RSP.
REQ-018 cmd_ready_o SHALL be high only in IDLE.
  - Command handshake in cycle N: capture addr/op/data; go to REQ; dmi_req_valid_o is high from cycle N+1.
REQ-019 In REQ, dmi_req_valid_o SHALL be high and the request fields SHALL hold the captured values, stable until dmi_req_ready_i is seen.
  - On handshake: go to WAIT.
REQ-020 dmi_resp_ready_o SHALL be high in WAIT and in IDLE.
  - A response that arrives in IDLE is accepted and discarded (drains stray responses).
REQ-021 On a response handshake in WAIT:
  - code 0: status 0, data captured.
  - code 2: status 2, data captured.
  - code 3 with retry count < MaxRetries: increment the retry count and return to REQ in the next cycle, re-issuing the same request.
  - code 3 with retry count = MaxRetries: status 3.
  - code 1 (reserved): treated as 2.
REQ-022 rsp_valid_o SHALL rise in the cycle after the terminating event, and rsp_data_o/rsp_status_o SHALL be held until rsp_ready_i is seen.
  - On rsp handshake: go to IDLE and clear the retry count.
  - rsp_data_o SHALL be 0 for statuses 1 and 3.
REQ-023 A nop (op 0) SHALL be issued exactly like any other op.
REQ-024 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
  - When it reaches TimeoutCycles with no pending handshake: drop dmi_req_valid_o and go to RSP with status 1.
  - A handshake in the same cycle as the timeout wins.
REQ-025 Busy re-issues SHALL NOT clear the timeout counter, so the timeout bounds the whole command.
REQ-026 Retry and timeout counter widths SHALL be 4 and 16 bits; neither SHALL wrap.

Reset
REQ-027 While rst_i is high, all outputs SHALL be 0, the state SHALL be IDLE and the counters and captured registers SHALL be 0.
REQ-028 Reset asserted mid-command SHALL abandon the command with no rsp_valid_o; the first cycle after release SHALL be IDLE with cmd_ready_o=1.

Configuration
REQ-029 Macro DMI_INITIATOR_TIMEOUT_EN SHALL control the timeout feature.
  - Defined: the timeout counter and status 1 exist as specified.
  - Undefined: no counter is built, the block waits indefinitely in REQ/WAIT, and status 1 is never produced.

Verification
REQ-030 Read addr 0x11, DM responds code 0 with data 0x00000C82 -> rsp_data_o=0x00000C82, status 0; dmi_req_valid_o rises one cycle after the cmd handshake; rsp_valid_o rises one cycle after the resp handshake.
REQ-031 Write addr 0x10, data 0x80000001, dmi_req_ready_i low for 5 cycles -> request fields stable for all 5 cycles, exactly one request handshake, status 0.
REQ-032 Read answered busy (code 3) 5 times with MaxRetries=4 -> 5 request handshakes, status 3, rsp_data_o=0; with 4 busy then ok -> status 0.
REQ-033 With TIMEOUT_EN, TimeoutCycles=16, dmi_req_ready_i held 0 -> dmi_req_valid_o drops after 16 cycles, status 1; a stray response then arrives in IDLE and is consumed with no rsp_valid_o.
REQ-034 rst_i pulsed during WAIT -> no rsp_valid_o, all outputs 0, cmd_ready_o=1 on the cycle after release; the next command completes normally.
